mem_axi_dpram_wr_ctrl: RTL

AXI4 write-channel slave that turns AW/W bursts into per-beat byte-strobed write commands for the team's synchronous simple dual-port RAM write port.

---
 rtl/mem_axi_dpram_wr_ctrl_pkg.sv | 33 +++
 rtl/mem_axi_dpram_wr_ctrl_if.sv | 49 ++++
 rtl/mem_axi_addr_gen.sv | 49 ++++
 rtl/mem_axi_dpram_wr_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_axi_dpram_wr_ctrl_pkg.sv
// Shared definitions for the AXI-to-DPRAM write controller and its helpers.
//   burst_t : AXI AWBURST encodings (FIXED / INCR / WRAP / reserved)
//   resp_t  : AXI BRESP encodings used by this slave (OKAY / SLVERR)
//   state_t : write-controller FSM states (IDLE / WRITE / RESP)
//   clogb2  : ceiling log2 used to derive lane-index widths
package mem_axi_dpram_wr_ctrl_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RESP
    } state_t;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_axi_dpram_wr_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between an AXI master and the
// DPRAM write controller.
//   master modport : drives AW*/W*/BREADY, observes AWREADY/WREADY/B*
//   slave  modport : the controller side
interface mem_axi_dpram_wr_ctrl_if
    import mem_axi_dpram_wr_ctrl_pkg::*;
#(
    parameter int WIDTH_AD = 10,
    parameter int WIDTH_DA = 32,
    parameter int WIDTH_ID = 4
);
    localparam int WIDTH_DS = WIDTH_DA / 8;

    logic [WIDTH_ID-1:0] AWID;
    logic [WIDTH_AD-1:0] AWADDR;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    logic [WIDTH_DA-1:0] WDATA;
    logic [WIDTH_DS-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [WIDTH_ID-1:0] BID;
    resp_t               BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/mem_axi_addr_gen.sv
// Combinational AXI burst address stepper, shared by the write and read
// side controllers.
//   addr      : address of the current beat
//   size      : log2 bytes per beat
//   len       : beats-1 of the burst
//   burst     : burst type; WRAP with a length outside {1,3,7,15} and the
//               reserved encoding both step as INCR
//   next_addr : address of the following beat (modulo 2^WIDTH_AD)
module mem_axi_addr_gen
    import mem_axi_dpram_wr_ctrl_pkg::*;
#(
    parameter int WIDTH_AD = 10
) (
    input  logic [WIDTH_AD-1:0] addr,
    input  logic [2:0]          size,
    input  logic [7:0]          len,
    input  burst_t              burst,
    output logic [WIDTH_AD-1:0] next_addr
);

    logic [WIDTH_AD-1:0] step;
    logic [WIDTH_AD-1:0] aligned;
    logic [WIDTH_AD-1:0] incr;
    logic [WIDTH_AD-1:0] cont;
    logic [WIDTH_AD-1:0] base;
    logic                wrap_ok;

    always_comb begin
        step    = WIDTH_AD'(1) << size;
        aligned = addr & ~(step - WIDTH_AD'(1));
        incr    = aligned + step;
        // Wrap container is (len+1) beats, naturally aligned to its size.
        cont    = (WIDTH_AD'(len) + WIDTH_AD'(1)) << size;
        base    = addr & ~(cont - WIDTH_AD'(1));
        wrap_ok = len inside {8'd1, 8'd3, 8'd7, 8'd15};

        next_addr = incr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP: begin
                // Stepping onto the container's upper boundary means wrap.
                if (wrap_ok && ((incr & (cont - WIDTH_AD'(1))) == '0))
                    next_addr = base;
            end
            default:     next_addr = incr;
        endcase
    end

endmodule

// File: rtl/mem_axi_dpram_wr_ctrl.sv
// AXI4 write slave feeding a simple dual-port RAM write port.
// Accepts one AW burst at a time, converts each W beat into a registered
// byte-strobed RAM write one cycle after the W handshake, and returns a
// single B response (SLVERR for WLAST misplacement, oversize AWSIZE,
// illegal WRAP length or reserved burst type).
//   CLK, RESETn : clock, synchronous active-low reset
//   s           : AXI write channels (AW/W/B), slave modport
//   MEM_WADDR   : RAM byte address
//   MEM_WDATA   : RAM write data
//   MEM_WSTRB   : RAM byte enables (WSTRB passed through unmodified)
//   MEM_WEN     : RAM write enable
module mem_axi_dpram_wr_ctrl
    import mem_axi_dpram_wr_ctrl_pkg::*;
#(
    parameter int WIDTH_AD  = 10,
    parameter int WIDTH_DA  = 32,
    parameter int WIDTH_DS  = WIDTH_DA / 8,
    parameter int WIDTH_DSB = clogb2(WIDTH_DS),
    parameter int WIDTH_ID  = 4
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    mem_axi_dpram_wr_ctrl_if.slave    s,
    output logic [WIDTH_AD-1:0]       MEM_WADDR,
    output logic [WIDTH_DA-1:0]       MEM_WDATA,
    output logic [WIDTH_DS-1:0]       MEM_WSTRB,
    output logic                      MEM_WEN
);

    localparam logic [2:0] MAX_SIZE = 3'(WIDTH_DSB);

    state_t              state, state_nxt;
    logic [WIDTH_ID-1:0] id_q;
    logic [WIDTH_AD-1:0] addr_q, addr_nxt;
    logic [7:0]          len_q;
    logic [7:0]          cnt_q;
    logic [2:0]          size_q;
    burst_t              burst_q;
    logic                err_q;
    logic                nowr_q;

    logic   aw_hs, w_hs, last_beat;
    logic   size_bad, wrap_bad, rsvd;
    burst_t burst_eff;

    assign aw_hs     = s.AWVALID & s.AWREADY;
    assign w_hs      = s.WVALID & s.WREADY;
    assign last_beat = (cnt_q == len_q);

    // AW-time error decode; illegal WRAP and reserved bursts run as INCR.
    always_comb begin
        size_bad  = s.AWSIZE > MAX_SIZE;
        rsvd      = s.AWBURST == BURST_RSVD;
        wrap_bad  = (s.AWBURST == BURST_WRAP) &&
                    !(s.AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15});
        burst_eff = (wrap_bad || rsvd) ? BURST_INCR : burst_t'(s.AWBURST);
    end

    mem_axi_addr_gen #(.WIDTH_AD(WIDTH_AD)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (addr_nxt)
    );

    always_ff @(posedge CLK) begin
        if (!RESETn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Ready/valid are qualified by RESETn so nothing handshakes during reset.
    always_comb begin
        state_nxt = state;
        s.AWREADY = 1'b0;
        s.WREADY  = 1'b0;
        s.BVALID  = 1'b0;
        case (state)
            ST_IDLE: begin
                s.AWREADY = RESETn;
                if (s.AWVALID) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                s.WREADY = RESETn;
                if (s.WVALID && last_beat) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                s.BVALID = RESETn;
                if (s.BREADY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign s.BID   = id_q;
    assign s.BRESP = err_q ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            err_q     <= 1'b0;
            nowr_q    <= 1'b0;
            MEM_WADDR <= '0;
            MEM_WDATA <= '0;
            MEM_WSTRB <= '0;
            MEM_WEN   <= 1'b0;
        end else begin
            MEM_WEN <= 1'b0;
            if (aw_hs) begin
                id_q    <= s.AWID;
                addr_q  <= s.AWADDR;
                len_q   <= s.AWLEN;
                size_q  <= s.AWSIZE;
                burst_q <= burst_eff;
                cnt_q   <= '0;
                err_q   <= size_bad | wrap_bad | rsvd;
                nowr_q  <= size_bad;
            end
            if (w_hs) begin
                MEM_WEN   <= ~nowr_q;
                MEM_WADDR <= addr_q;
                MEM_WDATA <= s.WDATA;
                MEM_WSTRB <= s.WSTRB;
                addr_q    <= addr_nxt;
                cnt_q     <= cnt_q + 8'd1;
                if (s.WLAST != last_beat) err_q <= 1'b1;
            end
        end
    end

endmodule
